rr_mux_arb_4: RTL

Round-robin arbiter that shares one 4-bit output channel between four valid/ready requesters. It selects a winner each cycle, steers the winner's data through a 4:1 selection, and registers the result into a single-entry output stage. It sits in front of any shared 4-bit consumer in the combinational-logic exercise set, turning the static `sel`-driven 4:1 mux into a scheduled, flow-controlled resource.

---
 rtl/rr_mux_arb_pkg.sv | 16 +
 rtl/mux4_w4.sv | 26 ++
 rtl/rr_pick_4.sv | 39 +++
 rtl/rr_mux_arb_4.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg
// Shared sizes and types for the 4-requester round-robin arbiter
// (rr_mux_arb_4) and its helpers.
// Optional feature macro used by the top: RR_MUX_ARB_LOCK_EN.
package rr_mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

  // One-hot vector with bit i set.
  function automatic req_vec_t idx_onehot(input idx_t i);
    return req_vec_t'(1) << i;
  endfunction
endpackage

// File: rtl/mux4_w4.sv
// mux4_w4
// 4:1 data multiplexer built from three 2:1 stages: two first-level
// stages on sel[0], one second-level stage on sel[1].
// Ports:
//   d0..d3  in   data inputs
//   sel     in   select index
//   y       out  selected data
module mux4_w4
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  idx_t             sel,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  assign lo = sel[0] ? d1 : d0;
  assign hi = sel[0] ? d3 : d2;
  assign y  = sel[1] ? hi : lo;
endmodule

// File: rtl/rr_pick_4.sv
// rr_pick_4
// Purely combinational round-robin pick: scans req starting at ptr and
// wrapping (ptr, ptr+1, ptr+2, ptr+3 mod 4); win is the first set bit.
// Ports:
//   req  in   request vector, bit i = requester i
//   ptr  in   highest-priority requester index
//   win  out  winning index (don't-care when any=0)
//   any  out  at least one request present
module rr_pick_4
  import rr_mux_arb_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     ptr,
  output idx_t     win,
  output logic     any
);
  // Rotate the request vector so that position 0 is the requester at ptr;
  // a fixed-priority search over the rotated vector then yields the offset.
  req_vec_t rot;
  idx_t     offset;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[idx_t'(ptr + idx_t'(gi))];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = idx_t'(k);
    end
  end

  // Two-bit addition wraps naturally (3 + 1 -> 0).
  assign win = ptr + offset;
  assign any = |req;
endmodule

// File: rtl/rr_mux_arb_4.sv
// rr_mux_arb_4
// Round-robin arbiter sharing one WIDTH-bit output channel between four
// valid/ready requesters. The winner's data is steered through a 4:1 mux
// and registered into a single-entry output stage.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_valid     request valid per requester
//   in_data      packed requester data, requester i at [i*WIDTH +: WIDTH]
//   in_ready     one-hot (or zero) accept strobe for this cycle
//   out_valid    output register holds a beat
//   out_data     granted data
//   out_idx      requester that supplied out_data
//   out_ready    consumer accepts when out_valid && out_ready
// Optional (macro RR_MUX_ARB_LOCK_EN):
//   in_last      per-requester end-of-packet flag; a beat with in_last=0
//                locks arbitration onto its requester until in_last=1
//   out_last     in_last of the stored beat
module rr_mux_arb_4
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  req_vec_t               in_valid,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output req_vec_t               in_ready,
`ifdef RR_MUX_ARB_LOCK_EN
  input  req_vec_t               in_last,
  output logic                   out_last,
`endif
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output idx_t                   out_idx,
  input  logic                   out_ready
);
  idx_t             ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  idx_t             out_idx_reg;

  req_vec_t         elig;
  idx_t             pick_ptr;
  idx_t             win;
  logic             any;
  logic             load;
  logic             last_beat;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] lane [N_REQ];

`ifdef RR_MUX_ARB_LOCK_EN
  logic locked_reg;
  idx_t lock_idx_reg;
  logic out_last_reg;

  // While a packet is in progress only its owner may win; starting the
  // search at lock_idx makes the owner the first candidate.
  assign elig      = locked_reg ? (in_valid & idx_onehot(lock_idx_reg)) : in_valid;
  assign pick_ptr  = locked_reg ? lock_idx_reg : ptr_reg;
  assign last_beat = in_last[win];
  assign out_last  = out_last_reg;
`else
  assign elig      = in_valid;
  assign pick_ptr  = ptr_reg;
  assign last_beat = 1'b1;
`endif

  rr_pick_4 u_pick (
    .req (elig),
    .ptr (pick_ptr),
    .win (win),
    .any (any)
  );

  // Accept when the output stage is empty or draining this cycle.
  assign load     = (!out_valid_reg || out_ready) && any;
  assign in_ready = load ? idx_onehot(win) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  mux4_w4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (lane[0]),
    .d1  (lane[1]),
    .d2  (lane[2]),
    .d3  (lane[3]),
    .sel (win),
    .y   (win_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= win_data;
      out_idx_reg   <= win;
      // Priority only rotates once a packet (or single beat) completes.
      if (last_beat) ptr_reg <= win + idx_t'(1);
    end else if (out_ready) begin
      // No load but consumer ready: either drained with nothing new, or
      // already empty. Data and index deliberately hold.
      out_valid_reg <= 1'b0;
    end
  end

`ifdef RR_MUX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_reg   <= 1'b0;
      lock_idx_reg <= '0;
      out_last_reg <= 1'b0;
    end else if (load) begin
      out_last_reg <= last_beat;
      locked_reg   <= !last_beat;
      if (!last_beat) lock_idx_reg <= win;
    end
  end
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_idx   = out_idx_reg;
endmodule
